calc_cmd_sequencer: RTL and testbench

Front-end controller placed between the raw board push-buttons/switches and the RPN calculator core. It synchronizes and debounces the Enter, Undo and DisplayFormat buttons, and queues each press as a pending command. It then issues the commands to the calculator one at a time, as single-cycle pulses in fixed priority order, with a guaranteed minimum spacing between them. Before each Enter pulse it captures a stable copy of the 16-bit switch operand, so the calculator never sees bounce, overlapping commands or a changing operand.

---
 rtl/calc_seq_pkg.sv | 48 ++++
 rtl/btn_debouncer.sv | 49 ++++
 rtl/calc_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_seq_pkg.sv
// calc_seq_pkg: shared types for the calculator command sequencer.
// Rev 1.0 - initial release.
`default_nettype none

package calc_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ISSUE = 2'd2,
      GAP   = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      CMD_UNDO  = 2'd0,
      CMD_ENTER = 2'd1,
      CMD_FMT   = 2'd2
   } cmd_e;

   localparam int PEND_W     = 3;
   localparam int PEND_FMT   = 0;
   localparam int PEND_ENTER = 1;
   localparam int PEND_UNDO  = 2;

   // Fixed priority: undo > enter > fmt.
   function automatic cmd_e pick_cmd(input logic [PEND_W-1:0] pend);
      if (pend[PEND_UNDO]) begin
         return CMD_UNDO;
      end else if (pend[PEND_ENTER]) begin
         return CMD_ENTER;
      end
      return CMD_FMT;
   endfunction

   function automatic logic [PEND_W-1:0] cmd_mask(input cmd_e c);
      logic [PEND_W-1:0] m;
      m = '0;
      case (c)
         CMD_UNDO:  m[PEND_UNDO]  = 1'b1;
         CMD_ENTER: m[PEND_ENTER] = 1'b1;
         default:   m[PEND_FMT]   = 1'b1;
      endcase
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debouncer.sv
// btn_debouncer: 2-FF synchronizer plus counter debouncer with rising-edge event.
// Rev 1.0 - initial release.
`default_nettype none

module btn_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic resetN,
   input  logic raw,
   output logic level,
   output logic rise_pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync_q1    <= 1'b0;
         sync_q2    <= 1'b0;
         level      <= 1'b0;
         cnt        <= '0;
         rise_pulse <= 1'b0;
      end else begin
         sync_q1    <= raw;
         sync_q2    <= sync_q1;
         rise_pulse <= 1'b0;
         if (sync_q2 != level) begin
            if (cnt == CNT_LAST) begin
               level      <= ~level;
               cnt        <= '0;
               rise_pulse <= ~level;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: debounces calculator buttons, queues presses and issues
// them as spaced single-cycle command pulses with a captured switch operand. Rev 1.0.
`default_nettype none

module calc_cmd_sequencer
   import calc_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int GAP_CYCLES      = 16,
   parameter int WIDTH           = 16
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             btn_enter_raw,
   input  logic             btn_undo_raw,
   input  logic             btn_fmt_raw,
   input  logic [WIDTH-1:0] sw_raw,
   output logic             enter,
   output logic             undo,
   output logic             display_format,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             dropped
);

   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [PEND_W-1:0] evt;
   logic [PEND_W-1:0] unused_level;
   logic [PEND_W-1:0] pending;
   logic [PEND_W-1:0] pend_clr;
   logic [WIDTH-1:0]  sw_q1;
   logic [WIDTH-1:0]  sw_q2;
   logic [GW-1:0]     gap_cnt;
   seq_state_e        state;
   seq_state_e        state_nxt;
   cmd_e              cmd;

   btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_undo (
      .clk        (clk),
      .resetN     (resetN),
      .raw        (btn_undo_raw),
      .level      (unused_level[PEND_UNDO]),
      .rise_pulse (evt[PEND_UNDO])
   );

   btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
      .clk        (clk),
      .resetN     (resetN),
      .raw        (btn_enter_raw),
      .level      (unused_level[PEND_ENTER]),
      .rise_pulse (evt[PEND_ENTER])
   );

   btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fmt (
      .clk        (clk),
      .resetN     (resetN),
      .raw        (btn_fmt_raw),
      .level      (unused_level[PEND_FMT]),
      .rise_pulse (evt[PEND_FMT])
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sw_q1 <= '0;
         sw_q2 <= '0;
      end else begin
         sw_q1 <= sw_raw;
         sw_q2 <= sw_q1;
      end
   end

   always_comb begin
      pend_clr = '0;
      if (state == ISSUE) begin
         pend_clr = cmd_mask(cmd);
      end
   end

   // A new press landing on the clearing bit re-queues rather than drops.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pending <= '0;
         dropped <= 1'b0;
      end else begin
         pending <= (pending & ~pend_clr) | evt;
         dropped <= |(evt & pending & ~pend_clr);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|pending) state_nxt = LOAD;
         LOAD:    state_nxt = ISSUE;
         ISSUE:   state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
         GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      enter          = 1'b0;
      undo           = 1'b0;
      display_format = 1'b0;
      busy           = (state != IDLE);
      if (state == ISSUE) begin
         case (cmd)
            CMD_UNDO:  undo           = 1'b1;
            CMD_ENTER: enter          = 1'b1;
            default:   display_format = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cmd      <= CMD_UNDO;
         gap_cnt  <= '0;
         data_out <= '0;
      end else begin
         if (state == IDLE && (|pending)) begin
            cmd <= pick_cmd(pending);
         end
         if (state == GAP && gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end
         if (state == LOAD && cmd == CMD_ENTER) begin
            data_out <= sw_q2;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_calc_cmd_sequencer.sv
// tb_calc_cmd_sequencer: directed scenarios plus random button traffic,
// compared cycle by cycle against a behavioural model of the sequencer.
`default_nettype none

module tb_calc_cmd_sequencer;

   localparam int DEB = 4;
   localparam int GAP = 3;
   localparam int W   = 16;

   logic         clk    = 1'b0;
   logic         resetN = 1'b0;
   logic         raw_btn [3];   // 0 = undo, 1 = enter, 2 = fmt (priority order)
   logic [W-1:0] sw_raw = '0;
   wire          enter, undo, display_format, busy, dropped;
   wire  [W-1:0] data_out;
   wire          btn_undo_raw  = raw_btn[0];
   wire          btn_enter_raw = raw_btn[1];
   wire          btn_fmt_raw   = raw_btn[2];

   calc_cmd_sequencer #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP), .WIDTH(W)) dut (
      .clk            (clk),
      .resetN         (resetN),
      .btn_enter_raw  (btn_enter_raw),
      .btn_undo_raw   (btn_undo_raw),
      .btn_fmt_raw    (btn_fmt_raw),
      .sw_raw         (sw_raw),
      .enter          (enter),
      .undo           (undo),
      .display_format (display_format),
      .data_out       (data_out),
      .busy           (busy),
      .dropped        (dropped)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural model: per-button synchronizer stages and debounce counts,
   // a pending flag per command, and a command "phase" index:
   // -1 idle, 0 operand load, 1 pulse, 2..GAP+1 spacing.
   int           m_s1 [3], m_s2 [3], m_lvl [3], m_cnt [3];
   bit           m_rise [3];
   bit           m_pend [3];
   bit           m_drop;
   int           m_ph, m_cmd;
   logic [W-1:0] m_sw1, m_sw2, m_data;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_cnt[i] = 0;
         m_rise[i] = 0; m_pend[i] = 0;
      end
      m_drop = 0; m_ph = -1; m_cmd = 0;
      m_sw1 = '0; m_sw2 = '0; m_data = '0;
   endtask

   task automatic model_step();
      bit old_pend [3];
      bit ev [3];
      bit clr [3];
      bit nr;
      for (int i = 0; i < 3; i++) begin
         old_pend[i] = m_pend[i];
         ev[i]  = m_rise[i];
         clr[i] = (m_ph == 1 && m_cmd == i);
      end
      if (m_ph < 0) begin
         for (int i = 2; i >= 0; i--) if (old_pend[i]) m_cmd = i;
         if (old_pend[0] || old_pend[1] || old_pend[2]) m_ph = 0;
      end else if (m_ph == 0) begin
         if (m_cmd == 1) m_data = m_sw2;
         m_ph = 1;
      end else if (m_ph == 1) begin
         m_ph = (GAP > 0) ? 2 : -1;
      end else begin
         m_ph = (m_ph == GAP + 1) ? -1 : m_ph + 1;
      end
      m_drop = 0;
      for (int i = 0; i < 3; i++) begin
         if (ev[i]) begin
            if (old_pend[i] && !clr[i]) m_drop = 1;
            m_pend[i] = 1;
         end else if (clr[i]) begin
            m_pend[i] = 0;
         end
      end
      for (int i = 0; i < 3; i++) begin
         nr = 0;
         if (m_s2[i] != m_lvl[i]) begin
            if (m_cnt[i] == DEB - 1) begin
               m_lvl[i] = 1 - m_lvl[i];
               m_cnt[i] = 0;
               nr = (m_lvl[i] == 1);
            end else begin
               m_cnt[i]++;
            end
         end else begin
            m_cnt[i] = 0;
         end
         m_rise[i] = nr;
         m_s2[i] = m_s1[i];
         m_s1[i] = int'(raw_btn[i]);
      end
      m_sw2 = m_sw1;
      m_sw1 = sw_raw;
   endtask

   int cyc = 0;
   int n_pulse [3];
   int n_drop, n_busy, n_overlap;
   int pulse_kind [$];
   int pulse_cyc [$];

   task automatic clear_stats();
      for (int i = 0; i < 3; i++) n_pulse[i] = 0;
      n_drop = 0; n_busy = 0; n_overlap = 0;
      pulse_kind.delete();
      pulse_cyc.delete();
   endtask

   task automatic tick();
      logic [W+4:0] exp_vec;
      @(posedge clk);
      if (resetN) model_step();
      @(negedge clk);
      cyc++;
      exp_vec = {(m_ph == 1 && m_cmd == 1), (m_ph == 1 && m_cmd == 0),
                 (m_ph == 1 && m_cmd == 2), (m_ph >= 0), m_drop, m_data};
      check("outputs", 32'({enter, undo, display_format, busy, dropped, data_out}),
            32'(exp_vec));
      if (32'(undo) + 32'(enter) + 32'(display_format) > 1) n_overlap++;
      if (undo)           begin n_pulse[0]++; pulse_kind.push_back(0); pulse_cyc.push_back(cyc); end
      if (enter)          begin n_pulse[1]++; pulse_kind.push_back(1); pulse_cyc.push_back(cyc); end
      if (display_format) begin n_pulse[2]++; pulse_kind.push_back(2); pulse_cyc.push_back(cyc); end
      if (dropped) n_drop++;
      if (busy) n_busy++;
   endtask

   task automatic set_all(input logic v);
      for (int i = 0; i < 3; i++) raw_btn[i] = v;
   endtask

   int t0;
   int hold [3];
   bit seen;

   initial begin
      // Reset with every input high.
      set_all(1'b1);
      sw_raw = 16'h1234;
      model_reset();
      @(negedge clk);
      repeat (3) tick();
      check("reset_outputs", 32'({enter, undo, display_format, busy, dropped, data_out}), 32'h0);
      resetN = 1'b1;
      clear_stats();
      repeat (40) tick();
      check("reset_release_enter_count", 32'(n_pulse[1]), 32'd1);
      check("reset_release_undo_count", 32'(n_pulse[0]), 32'd1);
      check("reset_release_fmt_count", 32'(n_pulse[2]), 32'd1);
      set_all(1'b0);
      repeat (20) tick();

      // Clean Enter.
      sw_raw = 16'h00A5;
      clear_stats();
      t0 = cyc;
      raw_btn[1] = 1'b1;
      repeat (10) tick();
      raw_btn[1] = 1'b0;
      repeat (30) tick();
      check("clean_enter_count", 32'(n_pulse[1]), 32'd1);
      check("clean_enter_latency", (pulse_cyc.size() > 0) ? 32'(pulse_cyc[0] - t0) : 32'hFFFF_FFFF,
            32'(2 + DEB + 3));
      check("clean_enter_data", 32'(data_out), 32'h00A5);
      check("clean_enter_busy_cycles", 32'(n_busy), 32'(2 + GAP));

      // Bounce on undo.
      clear_stats();
      for (int k = 0; k < 20; k++) begin
         raw_btn[0] = ~raw_btn[0];
         repeat (2) tick();
      end
      raw_btn[0] = 1'b0;
      repeat (10) tick();
      check("bounce_undo_count", 32'(n_pulse[0]), 32'd0);
      check("bounce_dropped", 32'(n_drop), 32'd0);

      // Simultaneous presses.
      sw_raw = 16'h5A5A;
      clear_stats();
      set_all(1'b1);
      repeat (10) tick();
      set_all(1'b0);
      repeat (40) tick();
      check("simul_pulse_count", 32'(pulse_kind.size()), 32'd3);
      if (pulse_kind.size() == 3) begin
         check("simul_order", 32'({pulse_kind[0][3:0], pulse_kind[1][3:0], pulse_kind[2][3:0]}), 32'h012);
         check("simul_spacing_1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(GAP + 3));
         check("simul_spacing_2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'(GAP + 3));
      end
      check("simul_overlap", 32'(n_overlap), 32'd0);
      check("simul_data", 32'(data_out), 32'h5A5A);

      // Overflow: second enter debounced while the first waits behind undo.
      clear_stats();
      raw_btn[0] = 1'b1; raw_btn[1] = 1'b1;
      repeat (4) tick();
      set_all(1'b0);
      repeat (4) tick();
      raw_btn[1] = 1'b1;
      repeat (4) tick();
      raw_btn[1] = 1'b0;
      repeat (40) tick();
      check("overflow_dropped", 32'(n_drop), 32'd1);
      check("overflow_enter_count", 32'(n_pulse[1]), 32'd1);
      check("overflow_undo_count", 32'(n_pulse[0]), 32'd1);

      // Reset during GAP with fmt still pending.
      clear_stats();
      raw_btn[0] = 1'b1; raw_btn[2] = 1'b1;
      seen = 0;
      for (int k = 0; k < 30 && !seen; k++) begin
         tick();
         if (undo) seen = 1;
      end
      check("midgap_undo_seen", 32'(seen), 32'd1);
      set_all(1'b0);
      tick();
      check("midgap_in_gap", 32'(busy), 32'd1);
      resetN = 1'b0;
      model_reset();
      tick();
      check("midgap_busy", 32'(busy), 32'd0);
      check("midgap_data", 32'(data_out), 32'd0);
      resetN = 1'b1;
      clear_stats();
      repeat (40) tick();
      check("midgap_no_fmt", 32'(n_pulse[2]), 32'd0);

      // Random traffic.
      for (int i = 0; i < 3; i++) hold[i] = 0;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 3; i++) begin
            if (hold[i] == 0) begin
               raw_btn[i] = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 12);
            end else begin
               hold[i]--;
            end
         end
         if ($urandom_range(0, 4) == 0) sw_raw = W'($urandom);
         if ($urandom_range(0, 799) == 0) begin
            resetN = 1'b0;
            model_reset();
            tick();
            resetN = 1'b1;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
